// File: rtl/ob_pkg.sv
// Order-book shared types: entry fields, priority-table commands, statuses and slot selects.
// Resident quantity sums are sized for tables of up to PQ_N_MAX slots.
package ob_pkg;

  localparam int UID_W      = 16;
  localparam int PRICE_W    = 32;
  localparam int QUANTITY_W = 16;
  localparam int PQ_N_MAX   = 16;
  localparam int QSUM_W     = QUANTITY_W + $clog2(PQ_N_MAX + 1);

  typedef logic [UID_W-1:0]      uid_t;
  typedef logic [PRICE_W-1:0]    price_t;
  typedef logic [QUANTITY_W-1:0] quantity_t;
  typedef logic [QSUM_W-1:0]     qsum_t;

  typedef struct packed {
    uid_t      uid;
    price_t    price;
    quantity_t quantity;
  } pq_entry_t;

  typedef enum logic [1:0] {
    PQ_INSERT = 2'd0,
    PQ_CANCEL = 2'd1,
    PQ_POP    = 2'd2,
    PQ_REDUCE = 2'd3
  } pq_op_t;

  typedef enum logic [2:0] {
    PQ_OK    = 3'd0,
    PQ_FULL  = 3'd1,
    PQ_MISS  = 3'd2,
    PQ_EMPTY = 3'd3,
    PQ_DUP   = 3'd4
  } pq_status_t;

  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_LOAD   = 3'd1,
    SEL_PREV   = 3'd2,
    SEL_NEXT   = 3'd3,
    SEL_REDUCE = 3'd4
  } slot_sel_t;

endpackage

// File: rtl/ob_pq_slot.sv
// One priority-table entry with its valid bit; next state chosen by the table's select.
// Updates on the clock edge after the select is presented; no flow control of its own.
module ob_pq_slot
  import ob_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  slot_sel_t sel,
  input  pq_entry_t load_ent,
  input  logic      prev_vld,
  input  pq_entry_t prev_ent,
  input  logic      next_vld,
  input  pq_entry_t next_ent,
  input  quantity_t red_amt,
  output logic      vld_r,
  output pq_entry_t ent_r
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_r <= 1'b0;
      ent_r <= '0;
    end else begin
      case (sel)
        SEL_LOAD: begin
          vld_r <= 1'b1;
          ent_r <= load_ent;
        end
        SEL_PREV: begin
          vld_r <= prev_vld;
          ent_r <= prev_ent;
        end
        SEL_NEXT: begin
          vld_r <= next_vld;
          ent_r <= next_ent;
        end
        // Partial fill only; the table removes the slot instead when the amount covers it.
        SEL_REDUCE: ent_r.quantity <= ent_r.quantity - red_amt;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ob_pq_table.sv
// Price-time priority table for one book side; commands take effect one cycle after acceptance.
// Single response register: cmd_rdy drops while a response is held unaccepted.
module ob_pq_table
  import ob_pkg::*;
#(
  parameter int N         = 16,
  parameter bit ASCENDING = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_vld,
  output logic                   cmd_rdy,
  input  pq_op_t                 cmd_op,
  input  pq_entry_t              cmd_entry,
  output logic                   rsp_vld_r,
  input  logic                   rsp_rdy,
  output pq_status_t             rsp_status_r,
  output pq_entry_t              rsp_entry_r,
  output logic                   head_vld_r,
  output pq_entry_t              head_r,
  output logic [$clog2(N+1)-1:0] count_r,
  output qsum_t                  quantity_r,
  output logic                   full_r,
  output logic                   empty_r
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N);

  logic [N-1:0] vld;
  pq_entry_t    ent      [N];
  logic [N-1:0] prev_vld;
  pq_entry_t    prev_ent [N];
  logic [N-1:0] next_vld;
  pq_entry_t    next_ent [N];
  slot_sel_t    sel      [N];

  logic         accept;
  logic [N-1:0] uid_hit;
  logic [N-1:0] cand;
  logic [N-1:0] ins_mask;
  logic [N-1:0] ins_first;
  logic [N-1:0] rm_src;
  logic [N-1:0] rm_mask;
  pq_entry_t    hit_ent;

  logic         do_ins;
  logic         do_rm;
  logic         do_red;
  quantity_t    filled;
  pq_status_t   status_nxt;
  pq_entry_t    rsp_ent_nxt;
  logic [CW-1:0] count_nxt;
  qsum_t        qsum_nxt;

  assign cmd_rdy = ~rsp_vld_r | rsp_rdy;
  assign accept  = cmd_vld & cmd_rdy;

  // UID CAM and "strictly worse price" vector; invalid slots are always acceptable insert points.
  always_comb begin
    uid_hit = '0;
    cand    = '0;
    hit_ent = '0;
    for (int i = 0; i < N; i++) begin
      uid_hit[i] = vld[i] && (ent[i].uid == cmd_entry.uid);
      if (ASCENDING)
        cand[i] = ~vld[i] | (ent[i].price > cmd_entry.price);
      else
        cand[i] = ~vld[i] | (ent[i].price < cmd_entry.price);
      if (uid_hit[i])
        hit_ent = ent[i];
    end
  end

  // Prefix-OR gives "at or after position" masks; the first set bit is the priority encode.
  always_comb begin
    ins_mask    = '0;
    rm_mask     = '0;
    ins_mask[0] = cand[0];
    rm_mask[0]  = rm_src[0];
    for (int i = 1; i < N; i++) begin
      ins_mask[i] = ins_mask[i-1] | cand[i];
      rm_mask[i]  = rm_mask[i-1] | rm_src[i];
    end
  end

  assign ins_first = cand & ~(ins_mask << 1);

  always_comb begin
    do_ins      = 1'b0;
    do_rm       = 1'b0;
    do_red      = 1'b0;
    rm_src      = '0;
    filled      = '0;
    status_nxt  = PQ_OK;
    rsp_ent_nxt = '0;
    count_nxt   = count_r;
    qsum_nxt    = quantity_r;
    case (cmd_op)
      PQ_INSERT: begin
        if (|uid_hit) begin
          status_nxt = PQ_DUP;
        end else if (count_r == N_CNT) begin
          status_nxt = PQ_FULL;
        end else begin
          do_ins      = 1'b1;
          rsp_ent_nxt = cmd_entry;
          count_nxt   = count_r + CW'(1);
          qsum_nxt    = quantity_r + QSUM_W'(cmd_entry.quantity);
        end
      end
      PQ_CANCEL: begin
        if (|uid_hit) begin
          do_rm       = 1'b1;
          rm_src      = uid_hit;
          rsp_ent_nxt = hit_ent;
          count_nxt   = count_r - CW'(1);
          qsum_nxt    = quantity_r - QSUM_W'(hit_ent.quantity);
        end else begin
          status_nxt = PQ_MISS;
        end
      end
      PQ_POP: begin
        if (!vld[0]) begin
          status_nxt = PQ_EMPTY;
        end else begin
          do_rm       = 1'b1;
          rm_src[0]   = 1'b1;
          rsp_ent_nxt = ent[0];
          count_nxt   = count_r - CW'(1);
          qsum_nxt    = quantity_r - QSUM_W'(ent[0].quantity);
        end
      end
      default: begin
        if (!vld[0]) begin
          status_nxt = PQ_EMPTY;
        end else begin
          if (cmd_entry.quantity < ent[0].quantity) begin
            do_red = 1'b1;
            filled = cmd_entry.quantity;
          end else begin
            do_rm     = 1'b1;
            rm_src[0] = 1'b1;
            filled    = ent[0].quantity;
            count_nxt = count_r - CW'(1);
          end
          rsp_ent_nxt          = ent[0];
          rsp_ent_nxt.quantity = filled;
          qsum_nxt             = quantity_r - QSUM_W'(filled);
        end
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      sel[i] = SEL_HOLD;
      if (accept) begin
        if (do_ins) begin
          if (ins_first[i])
            sel[i] = SEL_LOAD;
          else if (ins_mask[i])
            sel[i] = SEL_PREV;
        end else if (do_rm) begin
          if (rm_mask[i])
            sel[i] = SEL_NEXT;
        end else if (do_red && (i == 0)) begin
          sel[i] = SEL_REDUCE;
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_slot
    if (g == 0) begin : g_head
      assign prev_vld[g] = 1'b0;
      assign prev_ent[g] = '0;
    end else begin : g_body
      assign prev_vld[g] = vld[g-1];
      assign prev_ent[g] = ent[g-1];
    end
    // The tail slot pulls in zeros so a shift toward the head clears the vacated slot.
    if (g == N - 1) begin : g_tail
      assign next_vld[g] = 1'b0;
      assign next_ent[g] = '0;
    end else begin : g_inner
      assign next_vld[g] = vld[g+1];
      assign next_ent[g] = ent[g+1];
    end

    ob_pq_slot u_slot (
      .clk      (clk),
      .rst      (rst),
      .sel      (sel[g]),
      .load_ent (cmd_entry),
      .prev_vld (prev_vld[g]),
      .prev_ent (prev_ent[g]),
      .next_vld (next_vld[g]),
      .next_ent (next_ent[g]),
      .red_amt  (cmd_entry.quantity),
      .vld_r    (vld[g]),
      .ent_r    (ent[g])
    );
  end

  assign head_vld_r = vld[0];
  assign head_r     = ent[0];

  // full_r/empty_r are refreshed with each accepted command, so both read 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_vld_r    <= 1'b0;
      rsp_status_r <= PQ_OK;
      rsp_entry_r  <= '0;
      count_r      <= '0;
      quantity_r   <= '0;
      full_r       <= 1'b0;
      empty_r      <= 1'b0;
    end else if (accept) begin
      rsp_vld_r    <= 1'b1;
      rsp_status_r <= status_nxt;
      rsp_entry_r  <= rsp_ent_nxt;
      count_r      <= count_nxt;
      quantity_r   <= qsum_nxt;
      full_r       <= (count_nxt == N_CNT);
      empty_r      <= (count_nxt == '0);
    end else if (rsp_rdy) begin
      rsp_vld_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ob_pq_table.sv
// Directed bench for ob_pq_table: a bid-side and an ask-side table share one command stream.
module tb_ob_pq_table;
  import ob_pkg::*;

  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic       clk;
  logic       rst;
  logic       cmd_vld;
  logic       rsp_rdy;
  pq_op_t     cmd_op;
  pq_entry_t  cmd_entry;

  logic          b_cmd_rdy, b_rsp_vld, b_head_vld, b_full, b_empty;
  pq_status_t    b_status;
  pq_entry_t     b_rsp, b_head;
  logic [CW-1:0] b_count;
  qsum_t         b_qsum;

  logic          a_cmd_rdy, a_rsp_vld, a_head_vld, a_full, a_empty;
  pq_status_t    a_status;
  pq_entry_t     a_rsp, a_head;
  logic [CW-1:0] a_count;
  qsum_t         a_qsum;

  int n_chk = 0;
  int n_err = 0;

  ob_pq_table #(.N(N), .ASCENDING(1'b0)) dut_bid (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(b_cmd_rdy), .cmd_op(cmd_op),
    .cmd_entry(cmd_entry), .rsp_vld_r(b_rsp_vld), .rsp_rdy(rsp_rdy), .rsp_status_r(b_status),
    .rsp_entry_r(b_rsp), .head_vld_r(b_head_vld), .head_r(b_head), .count_r(b_count),
    .quantity_r(b_qsum), .full_r(b_full), .empty_r(b_empty)
  );

  ob_pq_table #(.N(N), .ASCENDING(1'b1)) dut_ask (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(a_cmd_rdy), .cmd_op(cmd_op),
    .cmd_entry(cmd_entry), .rsp_vld_r(a_rsp_vld), .rsp_rdy(rsp_rdy), .rsp_status_r(a_status),
    .rsp_entry_r(a_rsp), .head_vld_r(a_head_vld), .head_r(a_head), .count_r(a_count),
    .quantity_r(a_qsum), .full_r(a_full), .empty_r(a_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input pq_op_t op, input int uid, input int price, input int qty);
    cmd_op             = op;
    cmd_entry.uid      = uid_t'(uid);
    cmd_entry.price    = price_t'(price);
    cmd_entry.quantity = quantity_t'(qty);
  endtask

  // One command, accepted at the next rising edge; outputs sampled 1 time unit later.
  task automatic send(input pq_op_t op, input int uid, input int price, input int qty);
    @(negedge clk);
    cmd_vld = 1'b1;
    drive(op, uid, price, qty);
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    cmd_vld   = 1'b0;
    rsp_rdy   = 1'b0;
    cmd_op    = PQ_INSERT;
    cmd_entry = '0;
    repeat (3) @(negedge clk);

    chk("rst cmd_rdy", b_cmd_rdy, 1);
    chk("rst rsp_vld", b_rsp_vld, 0);
    chk("rst head_vld", b_head_vld, 0);
    chk("rst count", b_count, 0);
    chk("rst qsum", b_qsum, 0);
    chk("rst full", b_full, 0);
    chk("rst empty", b_empty, 0);
    chk("rst status", b_status, 0);

    rst     = 1'b1;
    rsp_rdy = 1'b1;

    send(PQ_INSERT, 1, 100, 10);
    chk("ins1 status", b_status, PQ_OK);
    chk("ins1 rsp uid", b_rsp.uid, 1);
    chk("ins1 rsp_vld", b_rsp_vld, 1);
    send(PQ_INSERT, 2, 105, 20);
    chk("ins2 bid head", b_head.uid, 2);
    chk("ins2 ask head", a_head.uid, 1);
    send(PQ_INSERT, 3, 100, 30);
    send(PQ_INSERT, 4, 95, 40);
    chk("ins4 bid head", b_head.uid, 2);
    chk("ins4 ask head", a_head.uid, 4);
    chk("ins4 count", b_count, 4);
    chk("ins4 qsum", b_qsum, 100);
    chk("ins4 ask qsum", a_qsum, 100);
    chk("ins4 full", b_full, 1);
    chk("ins4 empty", b_empty, 0);

    send(PQ_INSERT, 5, 200, 5);
    chk("full status", b_status, PQ_FULL);
    chk("full ask status", a_status, PQ_FULL);
    chk("full rsp uid", b_rsp.uid, 0);
    chk("full count", b_count, 4);
    chk("full qsum", b_qsum, 100);

    send(PQ_POP, 0, 0, 0);
    chk("pop1 bid", b_rsp.uid, 2);
    chk("pop1 ask", a_rsp.uid, 4);
    chk("pop1 bid qty", b_rsp.quantity, 20);
    chk("pop1 qsum", b_qsum, 80);
    send(PQ_POP, 0, 0, 0);
    chk("pop2 bid", b_rsp.uid, 1);
    chk("pop2 ask", a_rsp.uid, 1);
    send(PQ_POP, 0, 0, 0);
    chk("pop3 bid", b_rsp.uid, 3);
    chk("pop3 ask", a_rsp.uid, 3);
    send(PQ_POP, 0, 0, 0);
    chk("pop4 bid", b_rsp.uid, 4);
    chk("pop4 ask", a_rsp.uid, 2);
    chk("pop4 empty", b_empty, 1);
    chk("pop4 count", b_count, 0);
    chk("pop4 qsum", b_qsum, 0);
    chk("pop4 head_vld", b_head_vld, 0);

    send(PQ_POP, 0, 0, 0);
    chk("pop empty status", b_status, PQ_EMPTY);
    send(PQ_REDUCE, 0, 0, 3);
    chk("reduce empty status", b_status, PQ_EMPTY);

    send(PQ_INSERT, 10, 50, 10);
    send(PQ_INSERT, 11, 40, 7);
    send(PQ_INSERT, 12, 30, 3);
    send(PQ_INSERT, 11, 60, 1);
    chk("dup status", b_status, PQ_DUP);
    chk("dup count", b_count, 3);
    chk("dup qsum", b_qsum, 20);
    chk("dup head", b_head.uid, 10);

    send(PQ_REDUCE, 0, 0, 4);
    chk("red4 status", b_status, PQ_OK);
    chk("red4 filled", b_rsp.quantity, 4);
    chk("red4 uid", b_rsp.uid, 10);
    chk("red4 head qty", b_head.quantity, 6);
    chk("red4 qsum", b_qsum, 16);
    send(PQ_REDUCE, 0, 0, 9);
    chk("red9 filled", b_rsp.quantity, 6);
    chk("red9 uid", b_rsp.uid, 10);
    chk("red9 head", b_head.uid, 11);
    chk("red9 count", b_count, 2);
    chk("red9 qsum", b_qsum, 10);

    send(PQ_INSERT, 13, 35, 2);
    chk("ins13 head", b_head.uid, 11);
    send(PQ_CANCEL, 13, 0, 0);
    chk("cxl status", b_status, PQ_OK);
    chk("cxl uid", b_rsp.uid, 13);
    chk("cxl price", b_rsp.price, 35);
    chk("cxl count", b_count, 2);
    chk("cxl qsum", b_qsum, 10);
    send(PQ_POP, 0, 0, 0);
    chk("pop after cxl", b_rsp.uid, 11);
    chk("shifted head", b_head.uid, 12);
    chk("shifted count", b_count, 1);
    chk("shifted qsum", b_qsum, 3);

    send(PQ_CANCEL, 99, 0, 0);
    chk("miss status", b_status, PQ_MISS);
    chk("miss count", b_count, 1);

    @(negedge clk);
    cmd_vld = 1'b1;
    drive(PQ_INSERT, 20, 45, 2);
    @(posedge clk);
    #1;
    chk("b2b ins status", b_status, PQ_OK);
    drive(PQ_CANCEL, 20, 0, 0);
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
    chk("b2b cxl status", b_status, PQ_OK);
    chk("b2b cxl uid", b_rsp.uid, 20);
    chk("b2b count", b_count, 1);
    chk("b2b qsum", b_qsum, 3);

    repeat (2) @(negedge clk);
    rsp_rdy = 1'b0;
    send(PQ_INSERT, 21, 10, 1);
    chk("bp first status", b_status, PQ_OK);
    chk("bp first uid", b_rsp.uid, 21);
    @(negedge clk);
    cmd_vld = 1'b1;
    drive(PQ_INSERT, 22, 20, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("bp cmd_rdy", b_cmd_rdy, 0);
      chk("bp rsp_vld", b_rsp_vld, 1);
      chk("bp rsp held", b_rsp.uid, 21);
      chk("bp count held", b_count, 2);
    end
    @(negedge clk);
    rsp_rdy = 1'b1;
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
    chk("bp release uid", b_rsp.uid, 22);
    chk("bp release count", b_count, 3);
    chk("bp release qsum", b_qsum, 5);
    chk("bp release head", b_head.uid, 12);

    @(negedge clk);
    cmd_vld = 1'b1;
    drive(PQ_POP, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid rst rsp_vld", b_rsp_vld, 0);
    chk("mid rst head_vld", b_head_vld, 0);
    chk("mid rst head uid", b_head.uid, 0);
    chk("mid rst count", b_count, 0);
    chk("mid rst qsum", b_qsum, 0);
    chk("mid rst full", b_full, 0);
    chk("mid rst empty", b_empty, 0);
    chk("mid rst ask count", a_count, 0);
    chk("mid rst cmd_rdy", b_cmd_rdy, 1);
    cmd_vld = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
